// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the programmable clock/strobe generator.
package clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Half-period limit (in input cycles, minus one) for a given in/out frequency pair.
    function automatic int def_half(input int clk_in_hz, input int clk_out_hz);
        return clk_in_hz / clk_out_hz / 2 - 1;
    endfunction

endpackage

// File: rtl/clkgen_param.sv
// Runtime-programmable clock divider producing a registered square wave plus
// single-cycle rise/fall strobes. Divisor changes land only on full-period
// boundaries and stopping always finishes the current period with clk_out high.
module clkgen_param
    import clkgen_pkg::*;
#(
    parameter int CLK_IN_HZ  = 100_000_000,
    parameter int CLK_OUT_HZ = 200_000,
    parameter int CNT_W      = 16
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             running,
    output logic [CNT_W-1:0] div_active
);

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(def_half(CLK_IN_HZ, CLK_OUT_HZ));

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] pending;
    logic             pend_vld;
    logic             active;
    logic             hit;
    logic             rise_evt;
    logic             fall_evt;

    // State register.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: STOPPING keeps toggling and parks after the next rising edge of clk_out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = RUN;
            RUN:      if (!en) state_nxt = STOPPING;
            STOPPING: begin
                if (en)            state_nxt = RUN;
                else if (rise_evt) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Decoded toggle events for the current cycle; a 0->1 toggle is the period boundary.
    always_comb begin
        active   = (state != IDLE);
        hit      = active && (counter == div_active);
        rise_evt = hit && !clk_out;
        fall_evt = hit && clk_out;
    end

    // running tracks the registered state so it drops on the same edge clk_out parks high.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) running <= 1'b0;
        else        running <= (state_nxt != IDLE);
    end

    // Half-period counter, divided clock and strobes.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            counter   <= '0;
            clk_out   <= 1'b1;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            tick_rise <= rise_evt;
            tick_fall <= fall_evt;
            if (!active) begin
                counter <= '0;
                clk_out <= 1'b1;
            end else if (hit) begin
                counter <= '0;
                clk_out <= ~clk_out;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

    // Divisor staging: loads go to pending and are applied at a period boundary,
    // or straight away while idle. A load coinciding with a boundary stays pending.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            div_active <= DEF_HALF;
            pending    <= '0;
            pend_vld   <= 1'b0;
        end else if (!active) begin
            if (div_load) begin
                div_active <= div_value;
                pend_vld   <= 1'b0;
            end else if (pend_vld) begin
                div_active <= pending;
                pend_vld   <= 1'b0;
            end
        end else begin
            if (rise_evt && pend_vld) div_active <= pending;
            if (div_load) begin
                pending  <= div_value;
                pend_vld <= 1'b1;
            end else if (rise_evt) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clkgen_param.sv
// Self-checking bench for clkgen_param: directed scenarios plus random traffic,
// every cycle compared against a half-period countdown reference model.
module tb_clkgen_param;

    logic        clk_100MHz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en         = 1'b0;
    logic        div_load   = 1'b0;
    logic [15:0] div_value  = '0;
    logic        clk_out;
    logic        tick_rise;
    logic        tick_fall;
    logic        running;
    logic [15:0] div_active;

    int vectors = 0;
    int errs    = 0;

    // reference model state
    int m_mode;   // 0 parked, 1 running, 2 finishing last period
    int m_rem;    // edges left until the next toggle
    int m_lvl, m_tr, m_tf, m_run, m_div, m_pend, m_pv;

    clkgen_param dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .en         (en),
        .div_load   (div_load),
        .div_value  (div_value),
        .clk_out    (clk_out),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .running    (running),
        .div_active (div_active)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (!rst_n) begin
            m_mode = 0; m_lvl = 1; m_tr = 0; m_tf = 0; m_div = 249; m_pv = 0; m_rem = 0;
        end else if (m_mode == 0) begin
            m_tr = 0; m_tf = 0; m_lvl = 1;
            if (div_load) begin
                m_div = int'(div_value); m_pv = 0;
            end else if (m_pv != 0) begin
                m_div = m_pend; m_pv = 0;
            end
            if (en) begin
                m_mode = 1;
                m_rem  = m_div + 1;
            end
        end else begin
            rise = 0; m_tr = 0; m_tf = 0;
            m_rem--;
            if (m_rem == 0) begin
                m_lvl = 1 - m_lvl;
                if (m_lvl == 1) begin
                    m_tr = 1; rise = 1;
                    if (m_pv != 0) begin
                        m_div = m_pend; m_pv = 0;
                    end
                end else begin
                    m_tf = 1;
                end
                m_rem = m_div + 1;
            end
            if (div_load) begin
                m_pend = int'(div_value); m_pv = 1;
            end
            if (m_mode == 1 && !en)  m_mode = 2;
            else if (m_mode == 2) begin
                if (en)        m_mode = 1;
                else if (rise) m_mode = 0;
            end
        end
        m_run = (m_mode != 0) ? 1 : 0;
    endtask

    // one clock edge: update model with the inputs seen at the edge, then compare
    task automatic cyc();
        @(posedge clk_100MHz);
        model_step();
        #1;
        chk("clk_out",    int'(clk_out),    m_lvl);
        chk("tick_rise",  int'(tick_rise),  m_tr);
        chk("tick_fall",  int'(tick_fall),  m_tf);
        chk("running",    int'(running),    m_run);
        chk("div_active", int'(div_active), m_div);
    endtask

    // count edges until the requested strobe appears (bounded)
    task automatic wait_tick(input bit want_rise, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(want_rise ? tick_rise : tick_fall) && n < 2000);
    endtask

    initial begin
        int n, ticks;
        bit seen7;

        // reset
        repeat (3) cyc();
        chk("rst_clk_out", int'(clk_out), 1);
        chk("rst_div",     int'(div_active), 249);
        chk("rst_running", int'(running), 0);
        chk("rst_ticks",   int'(tick_rise) + int'(tick_fall), 0);

        // default 200 kHz: 250 high then 250 low
        rst_n = 1; en = 1;
        cyc();
        wait_tick(1'b0, n);
        chk("first_fall", n, 250);
        wait_tick(1'b1, n);
        chk("first_rise", n, 250);

        // divisor load mid high phase: current period finishes at 250/250
        repeat (10) cyc();
        div_load = 1; div_value = 16'd4;
        cyc();
        div_load = 0;
        wait_tick(1'b0, n);
        chk("old_high", n + 11, 250);
        chk("div_still_old", int'(div_active), 249);
        wait_tick(1'b1, n);
        chk("old_low", n, 250);
        chk("div_new", int'(div_active), 4);
        wait_tick(1'b0, n);
        chk("new_high", n, 5);
        wait_tick(1'b1, n);
        chk("new_low", n, 5);

        // stop during low phase: complete, rise, park
        wait_tick(1'b0, n);
        en = 0;
        wait_tick(1'b1, n);
        chk("stop_running", int'(running), 0);
        ticks = 0;
        repeat (1000) begin
            cyc();
            ticks += int'(tick_rise) + int'(tick_fall);
        end
        chk("parked_ticks", ticks, 0);
        chk("parked_clk", int'(clk_out), 1);

        // drop and re-raise en while stopping: model expects uninterrupted waveform
        en = 1;
        repeat (13) cyc();
        en = 0;
        repeat (3) cyc();
        en = 1;
        repeat (40) cyc();

        // divide-by-2, then reset mid-stream
        div_load = 1; div_value = 16'd0;
        cyc();
        div_load = 0;
        repeat (30) cyc();
        div_load = 1; div_value = 16'd2;   // pending that reset must discard
        cyc();
        div_load = 0;
        rst_n = 0;
        cyc();
        chk("rst2_clk_out", int'(clk_out), 1);
        chk("rst2_div", int'(div_active), 249);
        rst_n = 1;
        repeat (1100) cyc();               // spans two boundaries; div must stay 249

        // two loads within one period: only the last one lands
        seen7 = 0;
        div_load = 1; div_value = 16'd7;
        cyc();
        div_load = 0;
        repeat (20) begin cyc(); if (div_active == 16'd7) seen7 = 1; end
        div_load = 1; div_value = 16'd3;
        cyc();
        div_load = 0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (div_active == 16'd7) seen7 = 1;
        end
        chk("never7", int'(seen7), 0);
        chk("last_wins", int'(div_active), 3);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom_range(0, 99) < 85);
            div_load  = ($urandom_range(0, 99) < 8);
            div_value = 16'($urandom_range(0, 6));
            rst_n     = !($urandom_range(0, 999) < 3);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
